// File: rtl/xrv1_pkg.sv
// xrv1_pkg: shared writeback source/request types and the starvation counter width.
package xrv1_pkg;
  localparam int XRV1_XLEN      = 32;
  localparam int XRV1_REG_AW    = 5;
  localparam int XRV1_WB_WAIT_W = 4;
  typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MDU} wb_src_e;
  typedef struct packed {
    logic                   valid;
    logic [XRV1_REG_AW-1:0] rd_addr;
    logic [XRV1_XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/xrv1_wb_hold.sv
// xrv1_wb_hold: one-entry result hold with registered ready and a saturating wait counter.
module xrv1_wb_hold
  import xrv1_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  input  logic [XRV1_REG_AW-1:0]    rd_addr_i,
  input  logic [XRV1_XLEN-1:0]      data_i,
  input  logic                      grant_i,
  output logic                      ready_o,
  output wb_req_t                   req_o,
  output logic [XRV1_WB_WAIT_W-1:0] wait_o
);
  logic                      r_v;
  logic [XRV1_REG_AW-1:0]    r_rd;
  logic [XRV1_XLEN-1:0]      r_data;
  logic [XRV1_WB_WAIT_W-1:0] r_wait;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v    <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_wait <= '0;
    end else begin
      if (grant_i) r_v <= 1'b0;
      else if (valid_i && !r_v) begin
        r_v    <= 1'b1;
        r_rd   <= rd_addr_i;
        r_data <= data_i;
      end
      r_wait <= grant_i ? '0 : (r_v && !(&r_wait)) ? r_wait + 1'b1 : r_wait;
    end
  end
  assign ready_o = !r_v;
  assign req_o   = '{valid: r_v, rd_addr: r_rd, data: r_data};
  assign wait_o  = r_wait;
endmodule

// File: rtl/xrv1_wb_arb.sv
// xrv1_wb_arb: ALU/LSU/MDU writeback arbiter feeding the RF write port and scoreboard clear.
// Define XRV1_WB_BYPASS_EN to add the same-cycle RF write forwarding ports.
module xrv1_wb_arb
  import xrv1_pkg::*;
#(
  parameter int DATA_WIDTH_P    = XRV1_XLEN,
  parameter int RF_ADDR_WIDTH_P = XRV1_REG_AW,
  parameter int STARVE_MAX_P    = 4,
  localparam int RF_SIZE_LP     = 1 << RF_ADDR_WIDTH_P
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       alu_valid_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] alu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    alu_data_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [RF_ADDR_WIDTH_P-1:0] lsu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    lsu_data_i,
  input  logic                       mdu_valid_i,
  output logic                       mdu_ready_o,
  input  logic [RF_ADDR_WIDTH_P-1:0] mdu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    mdu_data_i,
  output logic                       alu_stall_o,
  output logic                       rd_w_en_o,
  output logic [RF_ADDR_WIDTH_P-1:0] rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]    rd_data_o,
  output logic [RF_SIZE_LP-1:0]      wb_clr_o
`ifdef XRV1_WB_BYPASS_EN
  ,
  input  logic [RF_ADDR_WIDTH_P-1:0] rs0_addr_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] rs1_addr_i,
  output logic                       rs0_fwd_hit_o,
  output logic                       rs1_fwd_hit_o,
  output logic [DATA_WIDTH_P-1:0]    fwd_data_o
`endif
);
  localparam logic [XRV1_WB_WAIT_W-1:0] STARVE_LP = XRV1_WB_WAIT_W'(STARVE_MAX_P);
  wb_req_t                   w_lsu, w_mdu, w_win;
  wb_src_e                   w_src;
  logic [XRV1_WB_WAIT_W-1:0] w_lsu_wait, w_mdu_wait;
  logic                      r_ptr;
  logic                      r_w_en, r_stall;
  logic [RF_ADDR_WIDTH_P-1:0] r_rd;
  logic [DATA_WIDTH_P-1:0]    r_data;
  xrv1_wb_hold u_lsu_hold (
    .clk_i, .rst_ni, .valid_i(lsu_valid_i), .rd_addr_i(lsu_rd_addr_i), .data_i(lsu_data_i),
    .grant_i(w_src == WB_SRC_LSU), .ready_o(lsu_ready_o), .req_o(w_lsu), .wait_o(w_lsu_wait)
  );
  xrv1_wb_hold u_mdu_hold (
    .clk_i, .rst_ni, .valid_i(mdu_valid_i), .rd_addr_i(mdu_rd_addr_i), .data_i(mdu_data_i),
    .grant_i(w_src == WB_SRC_MDU), .ready_o(mdu_ready_o), .req_o(w_mdu), .wait_o(w_mdu_wait)
  );
  // r_ptr low favours the LSU when both holds are waiting
  always_comb begin
    w_src = alu_valid_i ? WB_SRC_ALU :
            (w_lsu.valid && (!w_mdu.valid || !r_ptr)) ? WB_SRC_LSU :
            w_mdu.valid ? WB_SRC_MDU : WB_SRC_NONE;
    w_win = (w_src == WB_SRC_ALU) ? '{valid: 1'b1, rd_addr: alu_rd_addr_i, data: alu_data_i} :
            (w_src == WB_SRC_LSU) ? w_lsu :
            (w_src == WB_SRC_MDU) ? w_mdu : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w_en  <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_ptr   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_w_en  <= w_win.valid && |w_win.rd_addr;
      if (w_win.valid) begin
        r_rd   <= w_win.rd_addr;
        r_data <= w_win.data;
      end
      r_ptr   <= (w_src == WB_SRC_LSU) ? 1'b1 : (w_src == WB_SRC_MDU) ? 1'b0 : r_ptr;
      r_stall <= (w_lsu_wait >= STARVE_LP) || (w_mdu_wait >= STARVE_LP);
    end
  end
  assign alu_stall_o = r_stall;
  assign rd_w_en_o   = r_w_en;
  assign rd_addr_o   = r_rd;
  assign rd_data_o   = r_data;
  assign wb_clr_o    = r_w_en ? {{(RF_SIZE_LP-1){1'b0}}, 1'b1} << r_rd : '0;
`ifdef XRV1_WB_BYPASS_EN
  assign rs0_fwd_hit_o = r_w_en && r_rd == rs0_addr_i && |rs0_addr_i;
  assign rs1_fwd_hit_o = r_w_en && r_rd == rs1_addr_i && |rs1_addr_i;
  assign fwd_data_o    = r_data;
`endif
  a_alu_vs_stall: assert property (@(posedge clk_i) disable iff (!rst_ni) !(alu_valid_i && alu_stall_o));
endmodule

// File: tb/tb_xrv1_wb_arb.sv
// tb_xrv1_wb_arb: scoreboard bench with a queue-level reference model of the writeback arbiter.
module tb_xrv1_wb_arb;
  localparam int STARVE = 4;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mdu_valid_i = 1'b0;
  logic [4:0]  alu_rd_addr_i = '0, lsu_rd_addr_i = '0, mdu_rd_addr_i = '0;
  logic [31:0] alu_data_i = '0, lsu_data_i = '0, mdu_data_i = '0;
  logic        lsu_ready_o, mdu_ready_o, alu_stall_o, rd_w_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, wb_clr_o;

  xrv1_wb_arb #(.STARVE_MAX_P(STARVE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_addr_i(alu_rd_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_data_i(lsu_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_addr_i(mdu_rd_addr_i), .mdu_data_i(mdu_data_i),
    .alu_stall_o(alu_stall_o), .rd_w_en_o(rd_w_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .wb_clr_o(wb_clr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int cyc; logic [4:0] rd; logic [31:0] d;} wr_t;
  typedef struct {int cyc; logic rl; logic rm; logic st;} st_t;
  wr_t exp_wr[$];
  st_t exp_st[$];
  int n_tests = 0, n_fail = 0, cyc = 0;

  // Reference model: index 0 = LSU, 1 = MDU
  logic        m_hv[2], m_stall, m_ptr;
  logic [4:0]  m_rd[2];
  logic [31:0] m_d[2];
  int          m_cnt[2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_hv[i] = 0; m_cnt[i] = 0; m_rd[i] = '0; m_d[i] = '0; end
    m_ptr = 0; m_stall = 0;
    exp_wr.delete(); exp_st.delete();
  endtask

  task automatic step(logic av, logic [4:0] ar, logic [31:0] ad,
                      logic lv, logic [4:0] lr, logic [31:0] ld,
                      logic mv, logic [4:0] mr, logic [31:0] md);
    int win;
    logic [4:0] wrd;
    logic [31:0] wd;
    logic in_v[2];
    logic nxt_stall;
    alu_valid_i = av; alu_rd_addr_i = ar; alu_data_i = ad;
    lsu_valid_i = lv; lsu_rd_addr_i = lr; lsu_data_i = ld;
    mdu_valid_i = mv; mdu_rd_addr_i = mr; mdu_data_i = md;
    in_v[0] = lv; in_v[1] = mv;
    // win: -1 none, 2 ALU, 0 LSU, 1 MDU
    win = av ? 2 : (m_hv[0] && m_hv[1]) ? int'(m_ptr) : m_hv[0] ? 0 : m_hv[1] ? 1 : -1;
    wrd = (win == 2) ? ar : (win >= 0) ? m_rd[win] : 5'd0;
    wd  = (win == 2) ? ad : (win >= 0) ? m_d[win] : 32'd0;
    if (win >= 0 && wrd != 0) exp_wr.push_back('{cyc + 1, wrd, wd});
    nxt_stall = (m_cnt[0] >= STARVE) || (m_cnt[1] >= STARVE);
    for (int i = 0; i < 2; i++) begin
      if (win == i) begin
        m_hv[i] = 0; m_cnt[i] = 0; m_ptr = (i == 0);
      end else if (m_hv[i]) begin
        m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
      end else if (in_v[i]) begin
        m_hv[i] = 1;
        m_rd[i] = (i == 0) ? lr : mr;
        m_d[i]  = (i == 0) ? ld : md;
      end
    end
    m_stall = nxt_stall;
    exp_st.push_back('{cyc + 1, !m_hv[0], !m_hv[1], m_stall});
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rd_w_en_o) begin
        if (exp_wr.size() == 0) chk("spurious_write", {27'd0, rd_addr_o}, 64'hFFFF);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_addr", {59'd0, rd_addr_o}, {59'd0, e.rd});
          chk("wr_data", {32'd0, rd_data_o}, {32'd0, e.d});
          chk("wr_clr", {32'd0, wb_clr_o}, {32'd0, 32'd1 << e.rd});
        end
      end else begin
        chk("idle_clr", {32'd0, wb_clr_o}, 64'd0);
        if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("missing_write", 64'd0, {59'd0, e.rd});
        end
      end
      if (exp_st.size() != 0 && exp_st[0].cyc == cyc) begin
        st_t s;
        s = exp_st.pop_front();
        chk("lsu_ready", {63'd0, lsu_ready_o}, {63'd0, s.rl});
        chk("mdu_ready", {63'd0, mdu_ready_o}, {63'd0, s.rm});
        chk("alu_stall", {63'd0, alu_stall_o}, {63'd0, s.st});
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_w_en"}, {63'd0, rd_w_en_o}, 64'd0);
    chk({tag, "_addr"}, {59'd0, rd_addr_o}, 64'd0);
    chk({tag, "_data"}, {32'd0, rd_data_o}, 64'd0);
    chk({tag, "_clr"}, {32'd0, wb_clr_o}, 64'd0);
    chk({tag, "_stall"}, {63'd0, alu_stall_o}, 64'd0);
    chk({tag, "_lsu_rdy"}, {63'd0, lsu_ready_o}, 64'd1);
    chk({tag, "_mdu_rdy"}, {63'd0, mdu_ready_o}, 64'd1);
  endtask

  initial begin
    int k;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    // ALU single write
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Round-robin: LSU first, then MDU
    step(0, 0, 0, 1, 3, 32'h333, 1, 4, 32'h444);
    idle(4);
    // x0 suppression
    step(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
    idle(3);
    // Backpressure: second LSU result waits for the first to drain
    step(1, 1, 32'h11, 1, 6, 32'h66, 0, 0, 0);
    step(1, 2, 32'h22, 1, 7, 32'h77, 0, 0, 0);
    step(0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    step(0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    idle(4);
    // Starvation: ALU every cycle while an LSU result waits
    step(1, 8, 32'h88, 1, 9, 32'h99, 0, 0, 0);
    k = 0;
    while (!m_stall && k < 20) begin
      step(1, 5'(k + 10), 32'(k), 0, 0, 0, 0, 0, 0);
      k++;
    end
    chk("stall_raised", {63'd0, alu_stall_o}, 64'd1);
    idle(4);
    chk("stall_cleared", {63'd0, alu_stall_o}, 64'd0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic av;
      av = !m_stall && ($urandom_range(0, 2) == 0);
      step(av, 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
    end
    idle(8);
    // Async reset mid-cycle with both holds full
    step(1, 12, 32'hC0, 1, 13, 32'hD0, 1, 14, 32'hE0);
    step(1, 15, 32'hF0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    alu_valid_i = 0; lsu_valid_i = 0; mdu_valid_i = 0;
    model_reset();
    @(posedge clk_i);
    #1;
    cyc++;
    rst_ni = 1'b1;
    idle(6);
    chk("sb_wr_empty", 64'(exp_wr.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
